// File: rtl/fb_write_sched.sv
// -----------------------------------------------------------------------------
// fb_write_sched
//
// Write-port scheduler for the VGA frame-buffer RAM. N_REQ pixel producers
// share the single RAM write port through a round-robin arbiter. Writes are
// only issued while the raster is in vertical blanking, so scan-out never
// tears. A clear sequencer can take the port and wipe the whole buffer to one
// colour, pausing whenever the raster leaves blanking.
//
// Ports:
//   clk          in   VGA pixel clock
//   rst          in   synchronous, active-high reset
//   vc_in        in   current vertical count from the VGA timing block
//   req          in   per-requester write request
//   req_addr     in   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data     in   packed pixel data, requester i at [i*DATA_W +: DATA_W]
//   gnt          out  one-hot grant (combinational, same cycle as request)
//   clear_start  in   pulse: begin full-buffer clear
//   clear_color  in   colour written by the clear (sampled every clear write)
//   clear_busy   out  high while the clear sequencer owns the port
//   clear_done   out  one-cycle pulse when the clear completes
//   wr_en        out  RAM write enable (registered)
//   wr_addr      out  RAM write address (registered)
//   wr_data      out  RAM write data (registered)
//   frame_tick   out  one-cycle pulse when blanking begins
// -----------------------------------------------------------------------------
module fb_write_sched #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int FB_DEPTH = 19200,
    parameter int V_ACTIVE = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                vc_in,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    input  logic                      clear_start,
    input  logic [DATA_W-1:0]         clear_color,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      frame_tick
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_REQ - 1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(FB_DEPTH - 1);
    localparam logic [9:0]        VC_BLANK  = 10'(V_ACTIVE);

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_win_d;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_clear_busy;
    logic              r_clear_done;
    logic              r_frame_tick;

    logic              w_win;
    logic              w_found;
    logic [PTR_W-1:0]  w_idx;
    logic              w_grant;
    logic [N_REQ-1:0]  w_gnt;

    assign w_win = (vc_in >= VC_BLANK);

    // Round-robin search: start one past the last granted index and wrap, so
    // the most recent winner has the lowest priority on the next grant.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % N_REQ]) begin
                w_found = 1'b1;
                w_idx   = PTR_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    // clear_start outranks any request arriving in the same cycle.
    assign w_grant = (r_state == ST_ARB) && !clear_start && w_win && w_found;

    always_comb begin
        w_gnt = '0;
        if (w_grant) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register here samples the pre-edge values of the others.
        if (rst) begin
            r_state      <= ST_ARB;
            r_ptr        <= PTR_LAST;
            r_cnt        <= '0;
            r_win_d      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_win_d      <= w_win;
            r_frame_tick <= w_win && !r_win_d;
            // Pulses and the write strobe default low; branches below raise
            // them only for the cycle they apply to.
            r_wr_en      <= 1'b0;
            r_clear_done <= 1'b0;

            case (r_state)
                ST_ARB: begin
                    if (clear_start) begin
                        r_state      <= ST_CLEAR;
                        r_cnt        <= '0;
                        r_clear_busy <= 1'b1;
                    end else if (w_grant) begin
                        r_ptr     <= w_idx;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                        r_wr_data <= req_data[int'(w_idx)*DATA_W +: DATA_W];
                    end
                end

                ST_CLEAR: begin
                    // Outside blanking the clear simply holds its position.
                    if (w_win) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt;
                        r_wr_data <= clear_color;
                        if (r_cnt == CNT_LAST) begin
                            // Last word issued: hand the port back and flag
                            // completion on the same edge as that write.
                            r_state      <= ST_ARB;
                            r_cnt        <= '0;
                            r_clear_busy <= 1'b0;
                            r_clear_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    assign gnt        = w_gnt;
    assign clear_busy = r_clear_busy;
    assign clear_done = r_clear_done;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_tick = r_frame_tick;

endmodule

// File: doc/fb_write_sched.md
Name: fb_write_sched

Overview:
Write-port scheduler for the frame-buffer RAM that feeds the VGA scan-out. It arbitrates N_REQ pixel writers (Pac-Man sprite, ghosts, score, maze) onto the single RAM write port, round-robin. It only issues writes while the raster is in vertical blanking, so scan-out never tears. It also contains a clear sequencer that wipes the whole buffer to one colour, and it sits between the graphics producers and vga_ram.

Parameters:
N_REQ, 4, number of requesters
ADDR_W, 16, frame-buffer address width
DATA_W, 8, pixel width (RGB 3-3-2)
FB_DEPTH, 19200, number of frame-buffer words (160x120)
V_ACTIVE, 480, first vertical count that is blanking

Ports:
clk  in  1  VGA pixel clock (vgaclk domain)
rst  in  1  synchronous, active-high reset
vc_in  in  10  current vertical count from the VGA timing block
req  in  N_REQ  per-requester write request
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  N_REQ*DATA_W  packed pixel data, same packing
gnt  out  N_REQ  one-hot grant, combinational
clear_start  in  1  pulse: begin full-buffer clear
clear_color  in  DATA_W  colour used by the clear
clear_busy  out  1  high while the clear sequencer owns the port
clear_done  out  1  one-cycle pulse when the clear completes
wr_en  out  1  RAM write enable, registered
wr_addr  out  ADDR_W  RAM write address, registered
wr_data  out  DATA_W  RAM write data, registered
frame_tick  out  1  one-cycle pulse when blanking begins

Behaviour:
- Clock, reset and state:
  - Single clock; all state updates on the rising clk edge.
  - rst is synchronous and active-high.
  - Reset values: state=ARB, wr_en=0, wr_addr=0, wr_data=0, clear_busy=0, clear_done=0, frame_tick=0, clear counter=0, rr pointer=N_REQ-1 (so req[0] has first priority after reset).
- Write window:
  - win = (vc_in >= V_ACTIVE), compared combinationally each cycle.
  - frame_tick is registered and pulses the cycle after win goes 0 to 1 (previous-cycle win kept in a flop, reset 0).
- State ARB:
  - If win=1 and any req is high, gnt asserts for exactly one requester in the same cycle.
  - Search order starts at pointer+1 and wraps modulo N_REQ; on a grant, the pointer is updated to the granted index.
  - Next edge: wr_en=1, wr_addr/wr_data = the granted requester's req_addr/req_data slice. Write latency from grant is 1 cycle.
  - No grant, or win=0: gnt=0 and next wr_en=0.
  - Requester contract: hold req/addr/data stable until it sees gnt high; the cycle gnt is high counts as acceptance; on the following cycle it may keep req high for its next word or drop it.
  - Back-to-back grants to one requester are allowed only when no other requester is high.
- Clear start:
  - clear_start=1 in ARB moves the block to CLEAR at the next edge, with counter=0 and clear_busy=1.
  - If clear_start and requests arrive together, clear_start wins; gnt=0 that cycle.
- State CLEAR:
  - gnt=0 throughout.
  - Each cycle with win=1: next wr_en=1, wr_addr=counter, wr_data=clear_color (sampled each cycle), then counter increments.
  - When win=0 the clear pauses: wr_en=0, counter holds.
  - After the write of address FB_DEPTH-1 is issued, return to ARB at the next edge, clear_busy=0, and clear_done=1 for exactly one cycle.
  - clear_start while in CLEAR is ignored.
- Width and wrap:
  - The counter is ADDR_W bits and never exceeds FB_DEPTH-1.
  - Requester addresses pass through unchecked; range checking is the producer's job.
- rst mid-clear or mid-write: the block returns to reset values at the next edge. The clear is abandoned with no clear_done, and no partial write is issued after reset.

Test Plan:
- Reset, then vc_in=100 with req=4'b0001 held for 20 cycles -> gnt=0 and wr_en=0 throughout. Set vc_in=480 -> gnt=4'b0001 that cycle; next cycle wr_en=1 with req0's addr/data; frame_tick pulses once.
- vc_in=500, req=4'b1111 held continuously -> gnt sequence 0001,0010,0100,1000,0001; one wr_en per cycle with the matching addr/data.
- vc_in=500, req=4'b0101 after grant to requester 0 -> next grant goes to requester 2, then requester 0; requesters 1 and 3 are never granted.
- clear_start with clear_color=8'h00, vc_in toggling between 479 and 480 for 10 cycles each -> writes only in the vc_in=480 cycles; addresses 0..19199 are contiguous across pauses; clear_done pulses once after the 19200th write; gnt=0 while clear_busy=1.
- rst asserted at clear address 5000 -> next cycle clear_busy=0, wr_en=0, no clear_done. A subsequent req[3] is granted first only if req[0..2] are low; with req=4'b1001, req[0] is granted first.
